// File: rtl/ft_pkg.sv
// Shared types and default timing for the omux -> FT2232 FIFO write path.
// State encoding, byte width and the index-width helper live here.
package ft_pkg;

  localparam int BYTE_W          = 8;
  localparam int CNT_W           = 8;
  localparam int SI_W            = 16;

  localparam int DEF_SRC_COUNT   = 2;
  localparam int DEF_SETUP_CYC   = 1;
  localparam int DEF_WR_CYC      = 2;
  localparam int DEF_RECOVER_CYC = 4;
  localparam int DEF_SI_IDLE     = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_RECOVER
  } ft_state_e;

  // A single producer still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/omux_rr_arbiter.sv
// Round-robin grant among producers with record lock: a locked requester wins,
// otherwise the lowest-index requester at or after the pointer.
module omux_rr_arbiter
  import ft_pkg::*;
#(
  parameter int N  = DEF_SRC_COUNT,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic          lock_i,
  input  logic [IW-1:0] lock_idx_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  int j;

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    if (lock_i && req_i[lock_idx_i]) begin
      grant_o[lock_idx_i] = 1'b1;
      idx_o               = lock_idx_i;
      valid_o             = 1'b1;
    end else begin
      for (int i = 0; i < N; i++) begin
        j = int'(ptr_i) + i;
        if (j >= N) j = j - N;
        if (!valid_o && req_i[IW'(j)]) begin
          grant_o[IW'(j)] = 1'b1;
          idx_o           = IW'(j);
          valid_o         = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/omux_ft_writer.sv
// Pulls bytes from SRC_COUNT producers and writes them to the FT2232 FIFO (FT245 write).
// Optional send-immediate flush is enabled by defining OMUX_SI_FLUSH_EN.
module omux_ft_writer
  import ft_pkg::*;
#(
  parameter int SRC_COUNT   = DEF_SRC_COUNT,
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int WR_CYC      = DEF_WR_CYC,
  parameter int RECOVER_CYC = DEF_RECOVER_CYC,
  parameter int SI_IDLE     = DEF_SI_IDLE
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [BYTE_W*SRC_COUNT-1:0] src_data_i,
  input  logic [SRC_COUNT-1:0]        src_req_i,
  output logic [SRC_COUNT-1:0]        src_sel_o,
  input  logic                        ntxe_i,
  input  logic                        rx_busy_i,
  output logic                        wr_o,
  output logic [BYTE_W-1:0]           d_o,
  output logic                        d_oe_o,
  output logic                        tx_busy_o,
  output logic                        si_o
);

  localparam int IW = idx_width(SRC_COUNT);

  if (SRC_COUNT < 1 || SRC_COUNT > 8 || SETUP_CYC < 1 || WR_CYC < 1 ||
      RECOVER_CYC < 3 || SI_IDLE < 1) begin : g_param_check
    $error("omux_ft_writer: parameter out of range");
  end

  ft_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic             lock_q, lock_d;
  logic             ntxe_meta_q, ntxe_s_q;

  logic [SRC_COUNT-1:0] arb_grant;
  logic [IW-1:0]        arb_idx;
  logic                 arb_valid;
  logic [IW-1:0]        ptr_eff;
  logic                 start;
  logic                 rec_first;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IW'(SRC_COUNT - 1)) ? '0 : i + 1'b1;
  endfunction

  // Sync flops reset to "no room" so nothing is written until the FIFO reports space.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ntxe_meta_q <= 1'b1;
      ntxe_s_q    <= 1'b1;
    end else begin
      ntxe_meta_q <= ntxe_i;
      ntxe_s_q    <= ntxe_meta_q;
    end
  end

  // A released lock hands priority to the source after the one that just finished.
  assign ptr_eff = lock_q ? next_idx(idx_q) : ptr_q;

  omux_rr_arbiter #(.N(SRC_COUNT), .IW(IW)) u_arb (
    .req_i      (src_req_i),
    .lock_i     (lock_q),
    .lock_idx_i (idx_q),
    .ptr_i      (ptr_eff),
    .grant_o    (arb_grant),
    .idx_o      (arb_idx),
    .valid_o    (arb_valid)
  );

  assign start     = (state_q == ST_IDLE) && arb_valid && !ntxe_s_q && !rx_busy_i;
  assign rec_first = (state_q == ST_RECOVER) && (cnt_q == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
          state_d = ST_STROBE;
          cnt_d   = '0;
        end
      end
      ST_STROBE: begin
        if (cnt_q == CNT_W'(WR_CYC - 1)) begin
          state_d = ST_RECOVER;
          cnt_d   = '0;
        end
      end
      ST_RECOVER: begin
        if (cnt_q == CNT_W'(RECOVER_CYC - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    data_d = data_q;
    idx_d  = idx_q;
    ptr_d  = ptr_q;
    lock_d = lock_q;
    if (state_q == ST_IDLE) begin
      if (lock_q && !src_req_i[idx_q]) begin
        lock_d = 1'b0;
        ptr_d  = ptr_eff;
      end
      if (start) begin
        lock_d = 1'b1;
        idx_d  = arb_idx;
        for (int k = 0; k < SRC_COUNT; k++) begin
          if (arb_grant[k]) data_d = src_data_i[k*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // The pad stays driven for the first recover cycle so the FT latches stable data on wr fall.
  always_comb begin
    wr_o      = (state_q == ST_STROBE);
    d_oe_o    = (state_q == ST_SETUP) || (state_q == ST_STROBE) || rec_first;
    tx_busy_o = (state_q != ST_IDLE);
    d_o       = data_q;
    src_sel_o = '0;
    for (int k = 0; k < SRC_COUNT; k++) begin
      src_sel_o[k] = rec_first && (idx_q == IW'(k));
    end
  end

`ifdef OMUX_SI_FLUSH_EN
  logic [SI_W-1:0] idle_cnt_q, idle_cnt_d;
  logic            pend_q, pend_d;
  logic            si_q, si_d;
  logic            quiet;

  assign quiet = (state_q == ST_IDLE) && !(|src_req_i);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      idle_cnt_q <= '0;
      pend_q     <= 1'b0;
      si_q       <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      pend_q     <= pend_d;
      si_q       <= si_d;
    end
  end

  // Counter saturates so a flush held off by rx_busy fires as soon as the bus frees.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    pend_d     = pend_q;
    si_d       = 1'b0;
    if (|src_sel_o) begin
      idle_cnt_d = '0;
      pend_d     = 1'b1;
    end else if (!quiet) begin
      idle_cnt_d = '0;
    end else begin
      if (idle_cnt_q < SI_W'(SI_IDLE)) idle_cnt_d = idle_cnt_q + 1'b1;
      if (pend_q && !rx_busy_i && idle_cnt_q >= SI_W'(SI_IDLE - 1)) begin
        si_d   = 1'b1;
        pend_d = 1'b0;
      end
    end
  end

  assign si_o = si_q;
`else
  assign si_o = 1'b0;
`endif

endmodule

// File: tb/tb_omux_ft_writer.sv
// Directed bench for omux_ft_writer: two bench producers, a pad monitor logging every
// written byte at the wr_o falling edge, and hand-computed expectations.
module tb_omux_ft_writer;

  localparam int N           = 2;
  localparam int RECOVER_CYC = 4;
  localparam int SI_IDLE     = 64;

  logic           clk_i = 1'b0;
  logic           reset_i;
  logic [8*N-1:0] src_data_i;
  logic [N-1:0]   src_req_i;
  logic [N-1:0]   src_sel_o;
  logic           ntxe_i, rx_busy_i;
  logic           wr_o, d_oe_o, tx_busy_o, si_o;
  logic [7:0]     d_o;

  omux_ft_writer dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .src_data_i (src_data_i),
    .src_req_i  (src_req_i),
    .src_sel_o  (src_sel_o),
    .ntxe_i     (ntxe_i),
    .rx_busy_i  (rx_busy_i),
    .wr_o       (wr_o),
    .d_o        (d_o),
    .d_oe_o     (d_oe_o),
    .tx_busy_o  (tx_busy_o),
    .si_o       (si_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Bench producers: byte queues; a sel pulse advances the read pointer on the next edge.
  logic [7:0] mem [N][64];
  int         wr_ptr [N];
  int         rd_ptr [N];
  logic [N-1:0] en = '0;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      src_req_i[k]         = en[k] && (rd_ptr[k] != wr_ptr[k]);
      src_data_i[8*k +: 8] = mem[k][rd_ptr[k] % 64];
    end
  end

  always @(posedge clk_i) begin
    for (int k = 0; k < N; k++) if (src_sel_o[k]) rd_ptr[k] <= rd_ptr[k] + 1;
  end

  task automatic push(input int k, input logic [7:0] b);
    mem[k][wr_ptr[k] % 64] = b;
    wr_ptr[k] = wr_ptr[k] + 1;
  endtask

  // Pad monitor.
  int         cyc = 0;
  logic [7:0] wr_log [$];
  int         fall_q [$];
  int         rise_q [$];
  int         sel_cnt [N];
  int         sel_bad = 0;
  int         si_cnt = 0;
  int         si_cyc = 0;
  logic       prev_wr = 1'b0;
  logic       prev_si = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (reset_i) begin
      prev_wr <= 1'b0;
      prev_si <= 1'b0;
    end else begin
      if (wr_o && !prev_wr) rise_q.push_back(cyc);
      if (!wr_o && prev_wr) begin
        wr_log.push_back(d_o);
        fall_q.push_back(cyc);
      end
      if (|src_sel_o && !(!wr_o && prev_wr)) sel_bad <= sel_bad + 1;
      for (int k = 0; k < N; k++) if (src_sel_o[k]) sel_cnt[k] <= sel_cnt[k] + 1;
      if (si_o && !prev_si) begin
        si_cnt <= si_cnt + 1;
        si_cyc <= cyc;
      end
      prev_wr <= wr_o;
      prev_si <= si_o;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wait_log(input string tag, input int n, input int budget);
    int t = 0;
    while (wr_log.size() < n && t < budget) begin
      @(negedge clk_i); #1;
      t++;
    end
    check(tag, 32'(wr_log.size() >= n), 1);
  endtask

  task automatic expect_bytes(input string tag, input int base, input logic [7:0] exp [6], input int n);
    for (int i = 0; i < n; i++) begin
      if (base + i < wr_log.size()) check($sformatf("%s[%0d]", tag, i), 32'(wr_log[base + i]), 32'(exp[i]));
      else check($sformatf("%s[%0d]_missing", tag, i), 0, 1);
    end
  endtask

  initial begin
    int base, rb, c0, t, s0, hits, si0, sel_at;
    logic [7:0] exp [6];

    reset_i = 1'b1; ntxe_i = 1'b0; rx_busy_i = 1'b0;
    tick(3);
    check("rst_wr", 32'(wr_o), 0);
    check("rst_oe", 32'(d_oe_o), 0);
    check("rst_busy", 32'(tx_busy_o), 0);
    check("rst_sel", 32'(src_sel_o), 0);
    check("rst_d", 32'(d_o), 0);
    check("rst_si", 32'(si_o), 0);
    reset_i = 1'b0;
    tick(4);

    // 1: single producer, five bytes back to back
    base = wr_log.size(); rb = rise_q.size();
    for (int i = 0; i < 5; i++) push(0, 8'h11 + 8'(i));
    en = 2'b01; c0 = cyc;
    wait_log("t1_done", base + 5, 100);
    exp = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h00};
    expect_bytes("t1_byte", base, exp, 5);
    check("t1_latency", 32'(rise_q[rb] - c0), 2);
    for (int i = 1; i < 5; i++) check($sformatf("t1_period%0d", i), 32'(fall_q[base+i] - fall_q[base+i-1]), 8);
    check("t1_sel0", 32'(sel_cnt[0]), 5);
    tick(6);

    // 2b: pointer sits at 1 after src0's record, so src1 wins a simultaneous start
    en = 2'b00; base = wr_log.size();
    for (int i = 0; i < 3; i++) begin push(0, 8'hA0 + 8'(i)); push(1, 8'hB0 + 8'(i)); end
    en = 2'b11;
    wait_log("t2b_done", base + 6, 150);
    exp = '{8'hB0, 8'hB1, 8'hB2, 8'hA0, 8'hA1, 8'hA2};
    expect_bytes("t2b_order", base, exp, 6);
    tick(6);

    // 2: after reset the pointer is 0, src0's record goes first, never interleaved
    reset_i = 1'b1; en = 2'b00;
    tick(2);
    reset_i = 1'b0;
    tick(4);
    base = wr_log.size();
    for (int i = 0; i < 3; i++) begin push(0, 8'hC0 + 8'(i)); push(1, 8'hD0 + 8'(i)); end
    en = 2'b11;
    wait_log("t2_done", base + 6, 150);
    exp = '{8'hC0, 8'hC1, 8'hC2, 8'hD0, 8'hD1, 8'hD2};
    expect_bytes("t2_order", base, exp, 6);
    check("t2_sel1", 32'(sel_cnt[1]), 6);
    tick(6);

    // 3: FIFO fills after byte 2; remaining bytes wait for room
    en = 2'b00; base = wr_log.size();
    for (int i = 0; i < 4; i++) push(0, 8'h31 + 8'(i));
    en = 2'b01;
    wait_log("t3_two", base + 2, 60);
    ntxe_i = 1'b1;
    hits = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk_i); #1; if (wr_o) hits++; end
    check("t3_stalled_wr", 32'(hits), 0);
    check("t3_stalled_cnt", 32'(wr_log.size() - base), 2);
    rb = rise_q.size();
    tick(1);
    ntxe_i = 1'b0; c0 = cyc;
    wait_log("t3_done", base + 4, 60);
    check("t3_delay_ge3", 32'((rise_q[rb] - c0) >= 3 && (rise_q[rb] - c0) <= 8), 1);
    exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h00, 8'h00};
    expect_bytes("t3_byte", base, exp, 4);
    tick(6);

    // 4: rx path owns the pad; no write may start until it lets go
    rx_busy_i = 1'b1; en = 2'b00; base = wr_log.size();
    push(0, 8'h41); push(0, 8'h42);
    en = 2'b01;
    hits = 0;
    for (int i = 0; i < 15; i++) begin @(negedge clk_i); #1; if (d_oe_o || wr_o) hits++; end
    check("t4_blocked", 32'(hits), 0);
    tick(1);
    rx_busy_i = 1'b0;
    t = 0;
    while (!d_oe_o && t < 6) begin @(negedge clk_i); #1; t++; end
    check("t4_start_le2", 32'(t >= 1 && t <= 2), 1);
    wait_log("t4_done", base + 2, 60);
    exp = '{8'h41, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00};
    expect_bytes("t4_byte", base, exp, 2);
    tick(6);

    // 5: reset in the middle of the strobe aborts the byte without a sel pulse
    en = 2'b00; base = wr_log.size(); s0 = sel_cnt[0];
    push(0, 8'h51);
    en = 2'b01;
    t = 0;
    while (!wr_o && t < 20) begin @(negedge clk_i); #1; t++; end
    check("t5_reached_strobe", 32'(wr_o), 1);
    reset_i = 1'b1;
    #1;
    check("t5_wr_drop", 32'(wr_o), 0);
    check("t5_oe_drop", 32'(d_oe_o), 0);
    check("t5_busy_drop", 32'(tx_busy_o), 0);
    tick(3);
    check("t5_no_sel", 32'(sel_cnt[0] - s0), 0);
    reset_i = 1'b0;
    #1;
    check("t5_idle_busy", 32'(tx_busy_o), 0);
    check("t5_idle_sel", 32'(src_sel_o), 0);
    wait_log("t5_retry", base + 1, 60);
    check("t5_retry_byte", 32'(wr_log[base]), 32'h51);
    check("t5_retry_sel", 32'(sel_cnt[0] - s0), 1);
    tick(6);

    // 7: producer drops req mid-byte; the byte still completes and sel still pulses
    en = 2'b00; base = wr_log.size(); s0 = sel_cnt[1];
    push(1, 8'h71);
    en = 2'b10;
    t = 0;
    while (!tx_busy_o && t < 20) begin @(negedge clk_i); #1; t++; end
    en = 2'b00;
    wait_log("t7_done", base + 1, 40);
    check("t7_byte", 32'(wr_log[base]), 32'h71);
    check("t7_sel1", 32'(sel_cnt[1] - s0), 1);

    // 6: send-immediate after a quiet period
    si0 = si_cnt; sel_at = fall_q[fall_q.size() - 1];
    for (int i = 0; i < 90; i++) begin @(negedge clk_i); #1; end
`ifdef OMUX_SI_FLUSH_EN
    check("t6_si_pulses", 32'(si_cnt - si0), 1);
    check("t6_si_delay", 32'(si_cyc - sel_at), 32'(RECOVER_CYC + SI_IDLE));
`else
    check("t6_si_none", 32'(si_cnt - si0), 0);
    check("t6_si_low", 32'(si_o), 0);
`endif

    check("sel_aligned_with_wr_fall", 32'(sel_bad), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
